h14tx_period_scheduler: RTL and testbench

- Per-pixel period scheduler for the HDMI 1.4 TX encoder.
- Consumes the raster counters x/y and the decoded hsync/vsync. Decides each clock whether the TMDS lanes carry control, video preamble/guard, active video, or data-island preamble/guard/packet data.
- Sequences up to MaxPackets 32-clock packets per horizontal blanking, using a valid/ready handshake with the packet source.
- Sits between the timing counter/sync decode and the TMDS channel encoders.

---
 rtl/h14tx_period_scheduler.sv | 193 +++++++++++++++++++
 tb/tb_h14tx_period_scheduler.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/h14tx_period_scheduler.sv
// HDMI 1.4 TX period scheduler: picks control / video / data-island period per pixel
// from the raster counters and paces packet transfers with the packet source.
module h14tx_period_scheduler #(
  parameter int BitWidth   = 11,
  parameter int BitHeight  = 10,
  parameter int HActive    = 1280,
  parameter int HTotal     = 1650,
  parameter int VActive    = 720,
  parameter int VTotal     = 750,
  parameter int DiStart    = 1290,
  parameter int MaxPackets = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BitWidth-1:0]  x,
  input  logic [BitHeight-1:0] y,
  input  logic                 hsync_in,
  input  logic                 vsync_in,
  input  logic                 pkt_valid,
  output logic                 pkt_ready,
  output logic [4:0]           pkt_idx,
  output logic [2:0]           period,
  output logic [3:0]           ctl,
  output logic                 hsync,
  output logic                 vsync
);

  localparam logic [2:0] P_CONTROL   = 3'd0;
  localparam logic [2:0] P_VID_PRE   = 3'd1;
  localparam logic [2:0] P_VID_GUARD = 3'd2;
  localparam logic [2:0] P_VIDEO     = 3'd3;
  localparam logic [2:0] P_DI_PRE    = 3'd4;
  localparam logic [2:0] P_DI_GUARD  = 3'd5;
  localparam logic [2:0] P_DI_DATA   = 3'd6;

  localparam logic [BitWidth-1:0]  H_ACTIVE      = BitWidth'(HActive);
  localparam logic [BitWidth-1:0]  H_PRE_START   = BitWidth'(HTotal - 10);
  localparam logic [BitWidth-1:0]  H_PRE_END     = BitWidth'(HTotal - 3);
  localparam logic [BitWidth-1:0]  H_GUARD_START = BitWidth'(HTotal - 2);
  localparam logic [BitWidth-1:0]  DI_START      = BitWidth'(DiStart);
  localparam logic [BitHeight-1:0] V_ACTIVE      = BitHeight'(VActive);
  localparam logic [BitHeight-1:0] V_LAST        = BitHeight'(VTotal - 1);
  localparam logic [4:0]           MAX_PKT       = 5'(MaxPackets);

  // Islands must fit in blanking with at least 4 control clocks before any preamble.
  if (DiStart < HActive + 4) begin : g_bad_distart
    $fatal(1, "DiStart too close to active video");
  end
  if (DiStart + 8 + 2 + 32 * MaxPackets + 2 + 4 > HTotal - 10) begin : g_bad_fit
    $fatal(1, "data island does not fit in horizontal blanking");
  end
  if (MaxPackets < 1 || MaxPackets > 18) begin : g_bad_maxpkt
    $fatal(1, "MaxPackets out of range 1..18");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_LGUARD, S_DATA, S_TGUARD
  } di_state_t;

  di_state_t             st, nst;
  logic [4:0]            cnt, ncnt, npkt, nnpkt;
  logic                  ready_d;
  logic [BitHeight-1:0]  next_y;
  logic [2:0]            vid_period, period_d;
  logic [3:0]            vid_ctl, ctl_d;
  logic [4:0]            idx_d;

  assign next_y = (y == V_LAST) ? '0 : y + 1'b1;

  always_comb begin
    vid_period = P_CONTROL;
    vid_ctl    = 4'b0000;
    if (y < V_ACTIVE && x < H_ACTIVE) begin
      vid_period = P_VIDEO;
    end else if (next_y < V_ACTIVE && x >= H_PRE_START && x <= H_PRE_END) begin
      vid_period = P_VID_PRE;
      vid_ctl    = 4'b0001;
    end else if (next_y < V_ACTIVE && x >= H_GUARD_START) begin
      vid_period = P_VID_GUARD;
    end
  end

  // st/cnt hold the state of the pixel now on the outputs; nst/ncnt describe the current x.
  always_comb begin
    nst     = st;
    ncnt    = cnt;
    nnpkt   = npkt;
    ready_d = 1'b0;
    if (st != S_IDLE && x == '0) begin
      nst  = S_IDLE;
      ncnt = '0;
    end else begin
      case (st)
        S_IDLE: begin
          if (x == DI_START && pkt_valid) begin
            nst   = S_PRE;
            ncnt  = '0;
            nnpkt = '0;
          end
        end
        S_PRE: begin
          ncnt = cnt + 5'd1;
          if (cnt == 5'd7) begin
            nst  = S_LGUARD;
            ncnt = '0;
          end
        end
        S_LGUARD: begin
          ncnt = cnt + 5'd1;
          if (cnt == 5'd1) begin
            nst     = S_DATA;
            ncnt    = '0;
            nnpkt   = npkt + 5'd1;
            ready_d = 1'b1;
          end
        end
        S_DATA: begin
          ncnt = cnt + 5'd1;
          if (cnt == 5'd31) begin
            if (pkt_valid && npkt < MAX_PKT) begin
              ncnt    = '0;
              nnpkt   = npkt + 5'd1;
              ready_d = 1'b1;
            end else begin
              nst  = S_TGUARD;
              ncnt = '0;
            end
          end
        end
        S_TGUARD: begin
          ncnt = cnt + 5'd1;
          if (cnt == 5'd1) begin
            nst  = S_IDLE;
            ncnt = '0;
          end
        end
        default: begin
          nst  = S_IDLE;
          ncnt = '0;
        end
      endcase
    end
  end

  always_comb begin
    period_d = vid_period;
    ctl_d    = vid_ctl;
    idx_d    = '0;
    case (nst)
      S_PRE: begin
        period_d = P_DI_PRE;
        ctl_d    = 4'b0101;
      end
      S_LGUARD, S_TGUARD: begin
        period_d = P_DI_GUARD;
        ctl_d    = 4'b0000;
      end
      S_DATA: begin
        period_d = P_DI_DATA;
        ctl_d    = 4'b0000;
        idx_d    = ncnt;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= S_IDLE;
      cnt       <= '0;
      npkt      <= '0;
      period    <= P_CONTROL;
      ctl       <= 4'b0000;
      pkt_ready <= 1'b0;
      pkt_idx   <= '0;
      hsync     <= 1'b0;
      vsync     <= 1'b0;
    end else begin
      st        <= nst;
      cnt       <= ncnt;
      npkt      <= nnpkt;
      period    <= period_d;
      ctl       <= ctl_d;
      pkt_ready <= ready_d;
      pkt_idx   <= idx_d;
      hsync     <= hsync_in;
      vsync     <= vsync_in;
      assert (nst == S_IDLE || vid_period == P_CONTROL)
        else $error("data island overlaps a video period");
    end
  end

endmodule

// File: tb/tb_h14tx_period_scheduler.sv
// Bench for h14tx_period_scheduler: directed and random raster segments compared
// against a line-level reference model of video and data-island periods.
module tb_h14tx_period_scheduler;

  localparam int HA = 1280;
  localparam int HT = 1650;
  localparam int VA = 720;
  localparam int VT = 750;
  localparam int DS = 1290;
  localparam int MP = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] x = '0;
  logic [9:0]  y = '0;
  logic        hsync_in = 1'b0;
  logic        vsync_in = 1'b0;
  logic        pkt_valid = 1'b0;
  logic        pkt_ready;
  logic [4:0]  pkt_idx;
  logic [2:0]  period;
  logic [3:0]  ctl;
  logic        hsync;
  logic        vsync;

  int n_cmp = 0;
  int n_fail = 0;

  // reference model state: one island per line described by its start x and packet count
  bit isl_on = 1'b0;
  int isl_s = 0;
  int isl_np = 0;

  logic [2:0] e_period;
  logic [3:0] e_ctl;
  logic       e_ready;
  logic [4:0] e_idx;
  logic       e_hs, e_vs;
  int         e_x = 0, e_y = 0;
  bit         exp_ok = 1'b0;

  always #5 clk = ~clk;

  h14tx_period_scheduler #(
    .BitWidth(11), .BitHeight(10), .HActive(HA), .HTotal(HT),
    .VActive(VA), .VTotal(VT), .DiStart(DS), .MaxPackets(MP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .pkt_valid(pkt_valid),
    .pkt_ready(pkt_ready), .pkt_idx(pkt_idx), .period(period), .ctl(ctl),
    .hsync(hsync), .vsync(vsync)
  );

  function automatic logic [2:0] vid_ref(input int xv, input int yv);
    int ny;
    ny = (yv + 1) % VT;
    if (yv < VA && xv < HA) return 3'd3;
    if (ny < VA && xv >= HT - 10 && xv <= HT - 3) return 3'd1;
    if (ny < VA && xv >= HT - 2) return 3'd2;
    return 3'd0;
  endfunction

  function automatic bit valid_for(input int mode, input int xv);
    case (mode)
      0: return 1'b0;
      1: return 1'b1;
      2: return xv <= DS + 10;
      3: return xv > DS;
      default: return $urandom_range(0, 3) != 0;
    endcase
  endfunction

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("[TB] FAIL %s x=%0d y=%0d: observed %0h expected %0h", tag, e_x, e_y, obs, exp);
      end
  endtask

  task automatic check_output();
    check_val("period", 8'(period), 8'(e_period));
    check_val("ctl", 8'(ctl), 8'(e_ctl));
    check_val("pkt_ready", 8'(pkt_ready), 8'(e_ready));
    check_val("pkt_idx", 8'(pkt_idx), 8'(e_idx));
    check_val("hsync", 8'(hsync), 8'(e_hs));
    check_val("vsync", 8'(vsync), 8'(e_vs));
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_period"}, 8'(period), 8'd0);
    check_val({tag, "_ctl"}, 8'(ctl), 8'd0);
    check_val({tag, "_ready"}, 8'(pkt_ready), 8'd0);
    check_val({tag, "_idx"}, 8'(pkt_idx), 8'd0);
    check_val({tag, "_hsync"}, 8'(hsync), 8'd0);
    check_val({tag, "_vsync"}, 8'(vsync), 8'd0);
  endtask

  task automatic model_step(input int xv, input int yv, input bit valid);
    int pos;
    pos = 0;
    if (isl_on) begin
      if (xv == 0) begin
        isl_on = 1'b0;
      end else begin
        pos = xv - isl_s;
        if (pos > 10 && (pos - 10) % 32 == 0 && (pos - 10) / 32 == isl_np && valid && isl_np < MP)
          isl_np++;
        if (pos >= 12 + 32 * isl_np) isl_on = 1'b0;
      end
    end else if (xv == DS && valid) begin
      isl_on = 1'b1;
      isl_s  = xv;
      isl_np = 1;
    end
    e_ready = 1'b0;
    e_idx   = '0;
    e_ctl   = 4'b0000;
    if (isl_on) begin
      if (pos < 8) begin
        e_period = 3'd4;
        e_ctl    = 4'b0101;
      end else if (pos < 10 || pos >= 10 + 32 * isl_np) begin
        e_period = 3'd5;
      end else begin
        e_period = 3'd6;
        e_idx    = 5'((pos - 10) % 32);
        e_ready  = (e_idx == 5'd0);
      end
    end else begin
      e_period = vid_ref(xv, yv);
      if (e_period == 3'd1) e_ctl = 4'b0001;
    end
  endtask

  task automatic drive_pixel(input int xv, input int yv, input bit valid);
    x         = 11'(xv);
    y         = 10'(yv);
    pkt_valid = valid;
    hsync_in  = 1'($urandom);
    vsync_in  = 1'($urandom);
    e_hs      = hsync_in;
    e_vs      = vsync_in;
    e_x       = xv;
    e_y       = yv;
    model_step(xv, yv, valid);
    exp_ok    = 1'b1;
  endtask

  task automatic apply_stimulus(input int xv, input int yv, input bit valid);
    @(negedge clk);
    if (exp_ok) check_output();
    drive_pixel(xv, yv, valid);
  endtask

  task automatic run_seg(input int yv, input int x0, input int x1, input int mode);
    for (int i = x0; i <= x1; i++) apply_stimulus(i, yv, valid_for(mode, i));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    drive_pixel(0, 0, 1'b0);
    run_seg(0, 1, 20, 0);

    $display("[TB] video preamble and single packet");
    run_seg(10, 1280, HT - 1, 2);
    $display("[TB] two packets back to back");
    run_seg(11, 1280, HT - 1, 1);
    $display("[TB] late request then next-line island");
    run_seg(12, 1280, HT - 1, 3);
    run_seg(13, 0, 3, 1);
    run_seg(13, 1280, 1400, 1);
    run_seg(719, 1280, HT - 1, 0);
    run_seg(749, 1280, HT - 1, 0);
    run_seg(0, 0, 5, 0);

    $display("[TB] counter discontinuity");
    run_seg(30, 1285, 1310, 1);
    run_seg(31, 0, 5, 1);

    $display("[TB] reset mid-island");
    run_seg(40, 1285, 1305, 1);
    @(negedge clk);
    check_output();
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    isl_on = 1'b0;
    exp_ok = 1'b0;
    @(negedge clk);
    check_zero("held_reset");
    rst_n = 1'b1;
    drive_pixel(1306, 40, 1'b1);
    run_seg(40, 1307, 1340, 1);

    $display("[TB] random lines");
    for (int i = 0; i < 16; i++) begin
      int ry, mode;
      ry   = $urandom_range(0, VT - 1);
      mode = $urandom_range(0, 4);
      run_seg(ry, 1280, HT - 1, mode);
    end

    @(negedge clk);
    check_output();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
